mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port main memory between two masters:
  - port 0: the processor control unit (instruction fetch, LD/ST).
  - port 1: a secondary master (DMA / IO loader).
- Fixed priority to port 0, with a starvation bound guaranteeing port 1 service.
- Sequences each access as address issue, fixed-latency wait, capture and acknowledge, so masters see a clean req/ack handshake instead of raw memory timing.

Parameters:
- DATA_W, 16, data width of memory and both ports.
- ADDR_W, 16, address width.
- MEM_LAT, 2, cycles from the mem_en cycle to the mem_rdata valid cycle. Legal range 1..7.
- MAX_WAIT, 3, number of consecutive port-0 grants allowed while port 1 waits before port 1 is forced. Legal range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- r0_req  in  1  port 0 request, level, held until ack.
- r0_we  in  1  port 0 write (1) / read (0).
- r0_addr  in  ADDR_W  port 0 address.
- r0_wdata  in  DATA_W  port 0 write data.
- r0_ack  out  1  port 0 one-cycle completion pulse.
- r0_rdata  out  DATA_W  port 0 read data, valid when r0_ack=1.
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata  same as port 0, for port 1.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high when state != IDLE.
- gnt_id  out  1  port owning the current or last transaction.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0: r*_ack, r*_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_id.
  - Starvation counter wcnt = 0.
  - Reset mid-transaction abandons it: no ack is issued and mem_en is low on the next cycle.
- States:
  - IDLE: arbitrate.
    - r0_req only, or both with wcnt < MAX_WAIT: grant port 0.
    - r1_req only, or both with wcnt == MAX_WAIT: grant port 1.
    - On grant, latch gnt_id, we, addr and wdata from the granted port, then go to ISSUE.
    - No request: stay in IDLE.
  - ISSUE: exactly 1 cycle.
    - mem_en = 1; mem_we, mem_addr and mem_wdata come from the latched values.
    - Write: go to DONE. Read: go to WAIT with the wait counter = MEM_LAT.
  - WAIT: decrement the counter each cycle.
    - In the cycle the counter equals 1, capture mem_rdata into the shared rdata register, then go to DONE.
    - WAIT lasts exactly MEM_LAT cycles.
  - DONE: exactly 1 cycle.
    - ack = 1 on the granted port only; the other ack stays 0.
    - Go to IDLE.
- Latency, with t = the IDLE cycle in which the grant is made:
  - mem_en is high in cycle t+1.
  - Write ack in cycle t+2.
  - Read ack in cycle t+2+MEM_LAT. Example: MEM_LAT=2 gives ack at t+4.
- Read data:
  - r0_rdata and r1_rdata both drive the shared capture register.
  - Writes do not modify it; the value holds until the next read capture.
- Handshake:
  - Latched we/addr/wdata are immune to requester changes after the grant.
  - If a requester drops req mid-transaction, the transaction still completes and ack is still pulsed.
  - If req is still high in the IDLE cycle after DONE, it is treated as a new request, so back-to-back requests are legal.
  - Minimum spacing between mem_en pulses: 3 cycles for writes, MEM_LAT+3 for reads.
- Starvation counter wcnt:
  - On a port-0 grant while r1_req=1: wcnt saturates-increments toward MAX_WAIT.
  - On a port-1 grant: wcnt clears to 0.
  - In IDLE with r1_req=0: wcnt clears to 0.
  - Port 1 therefore waits at most MAX_WAIT port-0 transactions.
- busy = 1 in ISSUE, WAIT and DONE.
- mem_en is never high outside ISSUE. Only one transaction is ever outstanding.

Test Plan:
- Port 0 read (MEM_LAT=2): r0_req=1, r0_we=0, addr=0x0010, memory returns 0xBEEF → mem_en in cycle t+1 with mem_addr=0x0010; r0_ack=1 in cycle t+4 with r0_rdata=0xBEEF; r1_ack stays 0.
- Port 1 write: addr=0x0042, wdata=0x1234 → mem_en=mem_we=1 in t+1 with those values; r1_ack in t+2; rdata register unchanged.
- Contention (MAX_WAIT=3): r0_req and r1_req both held high for back-to-back transactions → grant order 0,0,0,1,0,0,0,1; wcnt returns to 0 after each port-1 grant.
- Requester changes r0_addr from 0x0010 to 0x0020 during WAIT → mem_addr stays 0x0010 and the ack arrives on schedule.
- Reset asserted during WAIT of a read → next cycle state IDLE, busy=0, no ack, wcnt=0; a new request after reset completes normally.
- Port 0 drops req during ISSUE → r0_ack still pulses once; arbiter returns to IDLE and, with no requests pending, stays idle with mem_en=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of a single-port, fixed-latency memory.
// Port 0 has priority; port 1 is forced after MAX_WAIT consecutive port-0 grants.
module mem_port_arbiter #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int MEM_LAT  = 2,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ack,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ack,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              gnt_id
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state;
   state_t            state_next;
   logic              gnt_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [3:0]        wcnt;
   logic [2:0]        lcnt;
   logic              any_req;
   logic              pick1;

   assign any_req = r0_req | r1_req;
   // Port 1 wins when alone, or when port 0 has used up its allowed run.
   assign pick1   = r1_req & (~r0_req | (wcnt == 4'(MAX_WAIT)));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (any_req) state_next = ISSUE;
         ISSUE: state_next = we_q ? DONE : WAIT;
         WAIT:  if (lcnt == 3'd1) state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wcnt    <= 4'd0;
         lcnt    <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt_q   <= pick1;
                  we_q    <= pick1 ? r1_we    : r0_we;
                  addr_q  <= pick1 ? r1_addr  : r0_addr;
                  wdata_q <= pick1 ? r1_wdata : r0_wdata;
               end
               // Count only port-0 grants that actually made port 1 wait.
               if (!r1_req || pick1)
                  wcnt <= 4'd0;
               else if (r0_req && wcnt != 4'(MAX_WAIT))
                  wcnt <= wcnt + 4'd1;
            end
            ISSUE: lcnt <= 3'(MEM_LAT);
            WAIT: begin
               lcnt <= lcnt - 3'd1;
               if (lcnt == 3'd1) rdata_q <= mem_rdata;
            end
            default: ;
         endcase
      end
   end

   assign mem_en    = (state == ISSUE);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state != IDLE);
   assign gnt_id    = gnt_q;
   assign r0_ack    = (state == DONE) & ~gnt_q;
   assign r1_ack    = (state == DONE) & gnt_q;
   assign r0_rdata  = rdata_q;
   assign r1_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model that
// only presents valid read data in the exact cycle MEM_LAT after mem_en.
module tb_mem_port_arbiter;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 16;
   localparam int MEM_LAT  = 2;
   localparam int MAX_WAIT = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              r0_req = 1'b0, r0_we = 1'b0;
   logic [ADDR_W-1:0] r0_addr = '0;
   logic [DATA_W-1:0] r0_wdata = '0;
   logic              r0_ack;
   logic [DATA_W-1:0] r0_rdata;
   logic              r1_req = 1'b0, r1_we = 1'b0;
   logic [ADDR_W-1:0] r1_addr = '0;
   logic [DATA_W-1:0] r1_wdata = '0;
   logic              r1_ack;
   logic [DATA_W-1:0] r1_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy, gnt_id;

   logic [DATA_W-1:0] read_value = 16'h0000;
   logic              pv [1:MEM_LAT];
   logic [DATA_W-1:0] pd [1:MEM_LAT];

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ack(r0_ack), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ack(r1_ack), .r1_rdata(r1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
   );

   always #5 clk = ~clk;

   // Read data is garbage (0xDEAD) except in the single cycle it is valid.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i <= MEM_LAT; i++) begin
            pv[i] <= 1'b0;
            pd[i] <= '0;
         end
      end else begin
         pv[1] <= mem_en & ~mem_we;
         pd[1] <= read_value;
         for (int i = 2; i <= MEM_LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
         end
      end
   end

   assign mem_rdata = pv[MEM_LAT] ? pd[MEM_LAT] : 16'hDEAD;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({mem_en, mem_we, busy, gnt_id, r0_ack, r1_ack} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got en/we/busy/gnt/ack0/ack1=%b expected 000000",
                  {mem_en, mem_we, busy, gnt_id, r0_ack, r1_ack});
      end
      checks++;
      if ({mem_addr, mem_wdata, r0_rdata, r1_rdata} !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_data: got addr=%h wdata=%h rd0=%h rd1=%h expected all 0",
                  mem_addr, mem_wdata, r0_rdata, r1_rdata);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_p0_read();
      r0_we = 1'b0; r0_addr = 16'h0010; read_value = 16'hBEEF; r0_req = 1'b1;
      tick();
      checks++;
      if ({mem_en, mem_we, gnt_id} !== 3'b100 || mem_addr !== 16'h0010) begin
         errors++;
         $display("[TB] FAIL p0_read_issue: got en/we/gnt=%b addr=%h expected 100 addr=0010",
                  {mem_en, mem_we, gnt_id}, mem_addr);
      end
      tick();
      tick();
      checks++;
      if (r0_ack !== 1'b0) begin
         errors++;
         $display("[TB] FAIL p0_read_early_ack: got r0_ack=%b at t+3 expected 0", r0_ack);
      end
      tick();
      checks++;
      if (r0_ack !== 1'b1 || r1_ack !== 1'b0 || r0_rdata !== 16'hBEEF) begin
         errors++;
         $display("[TB] FAIL p0_read_ack: got ack0=%b ack1=%b rdata=%h expected 1 0 beef",
                  r0_ack, r1_ack, r0_rdata);
      end
      r0_req = 1'b0;
      tick();
      checks++;
      if (r0_ack !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL p0_read_end: got ack0=%b busy=%b expected 0 0", r0_ack, busy);
      end
   endtask

   task automatic test_p1_write();
      r1_we = 1'b1; r1_addr = 16'h0042; r1_wdata = 16'h1234; r1_req = 1'b1;
      tick();
      checks++;
      if ({mem_en, mem_we, gnt_id} !== 3'b111 || mem_addr !== 16'h0042 || mem_wdata !== 16'h1234) begin
         errors++;
         $display("[TB] FAIL p1_write_issue: got en/we/gnt=%b addr=%h wdata=%h expected 111 0042 1234",
                  {mem_en, mem_we, gnt_id}, mem_addr, mem_wdata);
      end
      tick();
      checks++;
      if (r1_ack !== 1'b1 || r0_ack !== 1'b0 || r1_rdata !== 16'hBEEF) begin
         errors++;
         $display("[TB] FAIL p1_write_ack: got ack1=%b ack0=%b rdata=%h expected 1 0 beef",
                  r1_ack, r0_ack, r1_rdata);
      end
      r1_req = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic exp_order [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic got_order [8];
      int   got_cycle [8];
      int   n = 0;
      int   cyc = 0;
      r0_we = 1'b1; r0_addr = 16'h0100; r0_wdata = 16'h0A0A;
      r1_we = 1'b1; r1_addr = 16'h0200; r1_wdata = 16'h0B0B;
      r0_req = 1'b1; r1_req = 1'b1;
      while (n < 8 && cyc < 60) begin
         tick();
         cyc++;
         if (mem_en === 1'b1) begin
            got_order[n] = gnt_id;
            got_cycle[n] = cyc;
            if (gnt_id === 1'b1) begin
               checks++;
               if (dut.wcnt !== 4'd0) begin
                  errors++;
                  $display("[TB] FAIL b2b_wcnt_clear: got wcnt=%0d after port-1 grant %0d expected 0",
                           dut.wcnt, n);
               end
            end
            n++;
         end
      end
      r0_req = 1'b0; r1_req = 1'b0;
      checks++;
      if (n != 8) begin
         errors++;
         $display("[TB] FAIL b2b_timeout: got %0d grants in %0d cycles expected 8", n, cyc);
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_order[i] !== exp_order[i]) begin
               errors++;
               $display("[TB] FAIL b2b_order[%0d]: got gnt=%b expected %b", i, got_order[i], exp_order[i]);
            end
         end
         for (int i = 1; i < 8; i++) begin
            checks++;
            if (got_cycle[i] - got_cycle[i-1] != 3) begin
               errors++;
               $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles expected 3", i,
                        got_cycle[i] - got_cycle[i-1]);
            end
         end
      end
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || dut.wcnt !== 4'd0) begin
         errors++;
         $display("[TB] FAIL b2b_idle: got busy=%b wcnt=%0d expected 0 0", busy, dut.wcnt);
      end
   endtask

   task automatic test_addr_change();
      r0_we = 1'b0; r0_addr = 16'h0010; read_value = 16'h5A5A; r0_req = 1'b1;
      tick();
      tick();
      r0_addr = 16'h0020;
      tick();
      checks++;
      if (mem_addr !== 16'h0010 || r0_ack !== 1'b0) begin
         errors++;
         $display("[TB] FAIL addr_hold: got addr=%h ack0=%b expected 0010 0", mem_addr, r0_ack);
      end
      tick();
      checks++;
      if (r0_ack !== 1'b1 || r0_rdata !== 16'h5A5A || mem_addr !== 16'h0010) begin
         errors++;
         $display("[TB] FAIL addr_ack: got ack0=%b rdata=%h addr=%h expected 1 5a5a 0010",
                  r0_ack, r0_rdata, mem_addr);
      end
      r0_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      r0_we = 1'b0; r0_addr = 16'h0030; read_value = 16'h7777; r0_req = 1'b1;
      r1_we = 1'b1; r1_addr = 16'h0040; r1_req = 1'b1;
      tick();
      checks++;
      if (gnt_id !== 1'b0 || dut.wcnt !== 4'd1) begin
         errors++;
         $display("[TB] FAIL rst_mid_setup: got gnt=%b wcnt=%0d expected 0 1", gnt_id, dut.wcnt);
      end
      tick();
      reset = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
      tick();
      checks++;
      if ({busy, mem_en, r0_ack, r1_ack} !== 4'b0 || dut.wcnt !== 4'd0) begin
         errors++;
         $display("[TB] FAIL rst_mid_abort: got busy/en/ack0/ack1=%b wcnt=%0d expected 0000 0",
                  {busy, mem_en, r0_ack, r1_ack}, dut.wcnt);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({busy, r0_ack, r1_ack} !== 3'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_noack: got busy/ack0/ack1=%b cycle %0d expected 000",
                     {busy, r0_ack, r1_ack}, i);
         end
      end
      r0_we = 1'b1; r0_addr = 16'h0050; r0_wdata = 16'h0055; r0_req = 1'b1;
      tick();
      checks++;
      if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 16'h0050) begin
         errors++;
         $display("[TB] FAIL rst_mid_new_issue: got en/we=%b addr=%h expected 11 0050",
                  {mem_en, mem_we}, mem_addr);
      end
      tick();
      checks++;
      if (r0_ack !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_mid_new_ack: got ack0=%b expected 1", r0_ack);
      end
      r0_req = 1'b0;
      tick();
   endtask

   task automatic test_drop_req();
      r0_we = 1'b1; r0_addr = 16'h0060; r0_wdata = 16'hCAFE; r0_req = 1'b1;
      tick();
      r0_req = 1'b0;
      checks++;
      if (mem_en !== 1'b1 || mem_wdata !== 16'hCAFE) begin
         errors++;
         $display("[TB] FAIL drop_issue: got en=%b wdata=%h expected 1 cafe", mem_en, mem_wdata);
      end
      tick();
      checks++;
      if (r0_ack !== 1'b1) begin
         errors++;
         $display("[TB] FAIL drop_ack: got ack0=%b expected 1", r0_ack);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({mem_en, busy, r0_ack} !== 3'b0) begin
            errors++;
            $display("[TB] FAIL drop_idle: got en/busy/ack0=%b cycle %0d expected 000",
                     {mem_en, busy, r0_ack}, i);
         end
      end
   endtask

   initial begin
      test_reset();
      test_p0_read();
      test_p1_write();
      test_back_to_back();
      test_addr_change();
      test_reset_mid();
      test_drop_req();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
